// File: rtl/kernel3_fifo_srl_ctrl.sv
// Shift-register FIFO with first-word-fall-through output for kernel3 dataflow streams.
// A push is visible on if_dout one cycle later; requests against a full or empty side are ignored.
module kernel3_fifo_srl_ctrl #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic [ADDR_WIDTH:0]   if_num_data_valid
);

   localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] RA_ONE  = (ADDR_WIDTH)'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic                  full_n_q, full_n_d;
   logic                  empty_n_q, empty_n_d;

   logic push;
   logic pop;

   assign push = if_write & if_write_ce & full_n_q;
   assign pop  = if_read  & if_read_ce  & empty_n_q;

   // Storage is never reset; stale entries are unreachable once count returns to zero.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            mem_q[i] <= mem_q[i-1];
         end
         mem_q[0] <= if_din;
      end
   end

   // raddr tracks the oldest entry: it moves up on a lone push and down on a lone pop.
   always_comb begin
      count_d   = count_q;
      raddr_d   = raddr_q;
      full_n_d  = full_n_q;
      empty_n_d = empty_n_q;
      if (push && !pop) begin
         count_d   = count_q + CNT_ONE;
         empty_n_d = 1'b1;
         if (count_q != '0) begin
            raddr_d = raddr_q + RA_ONE;
         end
         if (count_q == CNT_MAX - CNT_ONE) begin
            full_n_d = 1'b0;
         end
      end else if (pop && !push) begin
         count_d  = count_q - CNT_ONE;
         full_n_d = 1'b1;
         if (count_q > CNT_ONE) begin
            raddr_d = raddr_q - RA_ONE;
         end
         if (count_q == CNT_ONE) begin
            empty_n_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         raddr_q   <= '0;
         full_n_q  <= 1'b1;
         empty_n_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         raddr_q   <= raddr_d;
         full_n_q  <= full_n_d;
         empty_n_q <= empty_n_d;
      end
   end

   assign if_dout           = mem_q[raddr_q];
   assign if_full_n         = full_n_q;
   assign if_empty_n        = empty_n_q;
   assign if_num_data_valid = count_q;

endmodule
